// File: rtl/sram_port_master.sv
// Valid/ready initiator for a single-port OpenRAM-style macro with a 4-entry read response FIFO.
// Optional post-reset zero-fill of the macro is enabled by defining SRAM_MST_INIT_EN.
module sram_port_master #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned CRED_W     = 4;

    logic                  init_wr;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  init_done_next;

`ifdef SRAM_MST_INIT_EN
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_next;
    logic [ADDR_WIDTH-1:0] init_addr_next;
    logic                  init_done_q;

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            init_addr   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state       <= state_next;
            init_addr   <= init_addr_next;
            init_done_q <= init_done_next;
        end
    end

    // Zero-fill walks every address once, then hands the port to the client.
    always_comb begin
        state_next     = state;
        init_addr_next = init_addr;
        init_wr        = 1'b0;
        case (state)
            ST_INIT: begin
                init_wr        = 1'b1;
                init_addr_next = init_addr + ADDR_WIDTH'(1);
                if (init_addr == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
        init_done_next = (state == ST_RUN);
    end

    assign init_done = init_done_q;
`else
    assign init_wr        = 1'b0;
    assign init_addr      = '0;
    assign init_done_next = 1'b1;
    assign init_done      = 1'b1;
`endif

    logic                  s0_rd;
    logic                  s1_rd;
    logic [DATA_WIDTH-1:0] fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  csb0_next;
    logic                  web0_next;
    logic [ADDR_WIDTH-1:0] addr0_next;
    logic [DATA_WIDTH-1:0] din0_next;
    logic                  s0_rd_next;
    logic [CNT_W-1:0]      count_next;
    logic [CRED_W-1:0]     inflight_next;
    logic                  req_ready_next;
    logic                  rsp_valid_next;

    // Credits count every read that will land in the FIFO, so req_ready is precomputed from next state.
    always_comb begin
        accept     = req_valid && req_ready;
        csb0_next  = 1'b1;
        web0_next  = 1'b1;
        addr0_next = addr0;
        din0_next  = din0;
        if (init_wr) begin
            csb0_next  = 1'b0;
            web0_next  = 1'b0;
            addr0_next = init_addr;
            din0_next  = '0;
        end else if (accept) begin
            csb0_next  = 1'b0;
            web0_next  = !req_we;
            addr0_next = req_addr;
            din0_next  = req_wdata;
        end
        s0_rd_next     = accept && !req_we;
        push           = s1_rd;
        pop            = rsp_valid && rsp_ready;
        count_next     = count + CNT_W'(push) - CNT_W'(pop);
        inflight_next  = CRED_W'(s0_rd_next) + CRED_W'(s0_rd) + CRED_W'(count_next);
        req_ready_next = init_done_next && (inflight_next < CRED_W'(FIFO_DEPTH));
        rsp_valid_next = (count_next != '0);
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            csb0      <= 1'b1;
            web0      <= 1'b1;
            addr0     <= '0;
            din0      <= '0;
            s0_rd     <= 1'b0;
            s1_rd     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rsp_valid <= 1'b0;
            req_ready <= 1'b0;
            fifo      <= '{default: '0};
        end else begin
            csb0      <= csb0_next;
            web0      <= web0_next;
            addr0     <= addr0_next;
            din0      <= din0_next;
            s0_rd     <= s0_rd_next;
            s1_rd     <= s0_rd;
            count     <= count_next;
            rsp_valid <= rsp_valid_next;
            req_ready <= req_ready_next;
            // mem_dout is only valid up to the macro's hold time, so capture on the edge itself.
            if (push) begin
                fifo[wr_ptr] <= mem_dout;
                wr_ptr       <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    assign rsp_rdata = fifo[rd_ptr];

endmodule

// File: tb/tb_sram_port_master.sv
// Bench for sram_port_master: behavioural single-port macro, reference memory and response scoreboard.
module tb_sram_port_master;

    localparam int DEPTH = 16;

    logic       clk0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       init_done;
    logic       csb0;
    logic       web0;
    logic [3:0] addr0;
    logic [7:0] din0;
    logic [7:0] mem_dout;

    sram_port_master #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk0(clk0), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .mem_dout(mem_dout)
    );

    int         n_cmp;
    int         n_err;
    int         n_pop;
    logic [7:0] ref_mem   [DEPTH];
    logic [7:0] macro_mem [DEPTH];
    logic [7:0] exp_q [$];

    always #5 clk0 = ~clk0;

    // Macro: samples pins at posedge, writes or drives dout at negedge, dout invalid after hold.
    logic       l_csb;
    logic       l_web;
    logic [3:0] l_addr;
    logic [7:0] l_din;
    always @(posedge clk0) begin
        l_csb  = csb0;
        l_web  = web0;
        l_addr = addr0;
        l_din  = din0;
        #1 mem_dout = 'x;
        @(negedge clk0);
        if (!l_csb) begin
            if (!l_web) macro_mem[l_addr] = l_din;
            else        mem_dout = macro_mem[l_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk0) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            else                   check("rsp_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
            n_pop++;
        end
    end

    // One clock: decide acceptance away from the edge, book-keep at the edge, return #1 after it.
    task automatic step(output bit acc);
        @(negedge clk0);
        acc = req_valid && req_ready;
        @(posedge clk0);
        if (acc) begin
            if (req_we) ref_mem[req_addr] = req_wdata;
            else        exp_q.push_back(ref_mem[req_addr]);
        end
        #1;
    endtask

    task automatic issue(input logic we, input logic [3:0] a, input logic [7:0] d, output int steps);
        bit acc;
        acc       = 1'b0;
        steps     = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!acc && steps < 50) begin
            step(acc);
            steps++;
        end
        req_valid = 1'b0;
        check("issue_accepted", 32'(acc), 32'd1);
    endtask

    task automatic release_reset();
        int n;
        bit done;
        req_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        rst_n = 1'b1;
`ifdef SRAM_MST_INIT_EN
        n    = 0;
        done = 1'b0;
        while (!done && n < 64) begin
            @(posedge clk0);
            #1;
            n++;
            done = init_done;
        end
        check("init_done_cycles", 32'(n), 32'(DEPTH + 1));
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
`else
        n    = 0;
        done = 1'b1;
        @(posedge clk0);
        #1;
        check("ready_first_cycle", 32'(req_ready), 32'd1);
        check("init_done_tied", 32'(init_done), 32'd1);
`endif
    endtask

    initial begin
        bit acc;
        int st;
        int total;
        int pops0;
        int acc_n;

        n_cmp = 0; n_err = 0; n_pop = 0;
        clk0 = 1'b0; rst_n = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]   = 8'h00;
            macro_mem[i] = 8'h00;
        end

        // Reset values
        #2 rst_n = 1'b0;
        #2;
        check("rst_csb0", 32'(csb0), 32'd1);
        check("rst_web0", 32'(web0), 32'd1);
        check("rst_addr0", 32'(addr0), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        release_reset();

        // Write then read the same address on the next cycle
        rsp_ready = 1'b0;
        issue(1'b1, 4'd3, 8'hA5, st);
        issue(1'b0, 4'd3, 8'h00, st);
        check("wr_rd_lat0", 32'(rsp_valid), 32'd0);
        step(acc);
        check("wr_rd_lat1", 32'(rsp_valid), 32'd0);
        step(acc);
        check("wr_rd_lat2_valid", 32'(rsp_valid), 32'd1);
        check("wr_rd_data", 32'(rsp_rdata), 32'hA5);
        rsp_ready = 1'b1;
        step(acc);
        check("wr_rd_drained", 32'(rsp_valid), 32'd0);

        // Streaming reads of the whole array
        for (int a = 0; a < DEPTH; a++) issue(1'b1, 4'(a), 8'(a) ^ 8'h5A, st);
        total = 0;
        pops0 = n_pop;
        for (int a = 0; a < DEPTH; a++) begin
            issue(1'b0, 4'(a), 8'h00, st);
            total += st;
        end
        repeat (3) step(acc);
        check("stream_cycles", 32'(total), 32'(DEPTH));
        check("stream_rsp_count", 32'(n_pop - pops0), 32'(DEPTH));
        check("stream_empty", 32'(rsp_valid), 32'd0);

        // Backpressure: six reads offered with the consumer stalled
        rsp_ready = 1'b0;
        acc_n     = 0;
        req_we    = 1'b0;
        req_addr  = 4'd8;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(acc);
            if (acc) begin acc_n++; req_addr = req_addr + 4'd1; end
        end
        check("bp_accepted_4", 32'(acc_n), 32'd4);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        for (int p = 0; p < 2; p++) begin
            rsp_ready = 1'b1;
            step(acc);
            if (acc) begin acc_n++; req_addr = req_addr + 4'd1; end
            rsp_ready = 1'b0;
            for (int i = 0; i < 2; i++) begin
                step(acc);
                if (acc) begin acc_n++; req_addr = req_addr + 4'd1; end
            end
            if (acc_n == 6) req_valid = 1'b0;
            check("bp_one_per_pop", 32'(acc_n), 32'(5 + p));
        end
        req_valid = 1'b0;
        pops0     = n_pop;
        rsp_ready = 1'b1;
        repeat (6) step(acc);
        check("bp_drain_count", 32'(n_pop - pops0), 32'd4);
        check("bp_drain_empty", 32'(rsp_valid), 32'd0);

        // Simultaneous push and pop with one entry held; enough rounds to wrap the pointers
        rsp_ready = 1'b0;
        issue(1'b0, 4'd0, 8'h00, st);
        repeat (2) step(acc);
        check("pp_prefill", 32'(rsp_valid), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            issue(1'b0, 4'(k), 8'h00, st);
            step(acc);
            rsp_ready = 1'b1;
            step(acc);
            rsp_ready = 1'b0;
            check("pp_count_kept", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        step(acc);
        rsp_ready = 1'b0;
        check("pp_single_left", 32'(rsp_valid), 32'd0);

        // Reset with two reads in flight
        rsp_ready = 1'b1;
        issue(1'b0, 4'd1, 8'h00, st);
        issue(1'b0, 4'd2, 8'h00, st);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_csb0", 32'(csb0), 32'd1);
        check("midrst_web0", 32'(web0), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        release_reset();
        for (int i = 0; i < 4; i++) begin
            step(acc);
            check("midrst_no_stale", 32'(rsp_valid), 32'd0);
        end

        // Full readback against the reference memory
        pops0 = n_pop;
        for (int a = 0; a < DEPTH; a++) issue(1'b0, 4'(a), 8'h00, st);
        repeat (3) step(acc);
        check("readback_count", 32'(n_pop - pops0), 32'(DEPTH));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
